// File: rtl/rpsc_status_filter_if.sv
// ----------------------------------------------------------------------------
// rpsc_status_filter_if
// Signal bundle between the field interlock contacts / operator panel and the
// rpsc_status_filter conditioning stage.
//
// Handshake: there is no valid/ready pairing on this bus. Every signal is a
// level that is sampled or updated on every rising clk edge. The producer
// (master) holds i_raw/i_ack. The filter (slave) presents its outputs every
// cycle.
//
// Signals:
//   i_raw       [N_CH] raw field contacts, active-high fault (asynchronous)
//   i_ack              operator fault-reset request, level sampled each cycle
//   o_filt      [N_CH] debounced live status
//   o_fault     [N_CH] latched faults
//   o_first     [3]    first-fault code: channel index + 1, 0 = none
//   o_trip             one-cycle pulse when the first fault latches
//   o_not_alarm        high when no fault latch is set
//   dbg_state          trip FSM state (0 = IDLE, 1 = TRIPPED)
// Modports:
//   master : drives i_raw/i_ack and observes the outputs
//   slave  : the filter itself
// ----------------------------------------------------------------------------
interface rpsc_status_filter_if #(
    parameter int N_CH = 7
);
    logic [N_CH-1:0] i_raw;
    logic            i_ack;
    logic [N_CH-1:0] o_filt;
    logic [N_CH-1:0] o_fault;
    logic [2:0]      o_first;
    logic            o_trip;
    logic            o_not_alarm;
    logic            dbg_state;

    modport master (
        output i_raw, i_ack,
        input  o_filt, o_fault, o_first, o_trip, o_not_alarm, dbg_state
    );

    modport slave (
        input  i_raw, i_ack,
        output o_filt, o_fault, o_first, o_trip, o_not_alarm, dbg_state
    );
endinterface

// File: rtl/rpsc_status_filter.sv
// ----------------------------------------------------------------------------
// rpsc_status_filter
// Input conditioning for the CARD1 interlock logic. Each raw field contact is
// passed through a two-flop synchroniser and a symmetric debounce counter.
// Every new filtered fault is latched until the operator acknowledges it. A
// two-state FSM records which channel tripped first.
//
// Ports:
//   clk    in  system clock (1.28 us)
//   reset  in  synchronous, active-high reset
//   bus    slave modport of rpsc_status_filter_if (raw contacts, ack,
//          filtered status, latches, first-fault code, trip pulse, alarm
//          summary, FSM debug state)
// Channel bit order: 0 Card_POS, 1 Air_Grid, 2 Water_Anode, 3 Water_Grid,
//                    4 DC_PS, 5 U_CA_Low, 6 I_CA_High.
// ----------------------------------------------------------------------------
module rpsc_status_filter #(
    parameter int N_CH       = 7,
    parameter int DEB_WIDTH  = 14,
    parameter int DEB_CYCLES = 7812
) (
    input  logic                  clk,
    input  logic                  reset,
    rpsc_status_filter_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, TRIPPED = 1'b1} state_t;

    localparam logic [DEB_WIDTH-1:0] CNT_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

    logic [N_CH-1:0]      s1, s2;
    logic [N_CH-1:0]      filt, filt_d;
    logic [DEB_WIDTH-1:0] cnt [N_CH];
    logic [N_CH-1:0]      fault, fault_nxt;
    logic [N_CH-1:0]      rise, clr;
    logic [2:0]           first, first_nxt, low_code;
    logic                 trip, trip_nxt;
    state_t               state, state_nxt;

    // Synchroniser and debounce. A channel's counter only runs while the
    // synchronised input disagrees with the accepted level. Any cycle of
    // agreement restarts it, so bounce never accumulates.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
        end else begin
            s1     <= bus.i_raw;
            s2     <= s1;
            filt_d <= filt;
            for (int k = 0; k < N_CH; k++) begin
                if (s2[k] == filt[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    filt[k] <= s2[k];
                    cnt[k]  <= '0;
                end else begin
                    cnt[k] <= cnt[k] + DEB_WIDTH'(1);
                end
            end
        end
    end

    // Latch update: ack clears only channels whose live status is already
    // low. A rise in the same cycle sets the latch, and the set wins.
    always_comb begin
        rise      = filt & ~filt_d;
        clr       = bus.i_ack ? ~filt : '0;
        fault_nxt = (fault & ~clr) | rise;
    end

    // Lowest-index rising channel, encoded as index + 1.
    always_comb begin
        low_code = 3'd0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rise[k]) low_code = 3'(k + 1);
        end
    end

    // Trip FSM next-state / outputs.
    always_comb begin
        state_nxt = state;
        first_nxt = first;
        trip_nxt  = 1'b0;
        case (state)
            IDLE: begin
                first_nxt = 3'd0;
                if (|rise) begin
                    first_nxt = low_code;
                    trip_nxt  = 1'b1;
                    state_nxt = TRIPPED;
                end
            end
            TRIPPED: begin
                // Return to IDLE only when this ack empties every latch.
                if (bus.i_ack && !(|filt) && !(|rise)) begin
                    first_nxt = 3'd0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                first_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fault <= '0;
            first <= 3'd0;
            trip  <= 1'b0;
        end else begin
            state <= state_nxt;
            fault <= fault_nxt;
            first <= first_nxt;
            trip  <= trip_nxt;
        end
    end

    assign bus.o_filt      = filt;
    assign bus.o_fault     = fault;
    assign bus.o_first     = first;
    assign bus.o_trip      = trip;
    assign bus.o_not_alarm = ~|fault;
    assign bus.dbg_state   = (state == TRIPPED);

endmodule

// File: tb/tb_rpsc_status_filter.sv
// ----------------------------------------------------------------------------
// tb_rpsc_status_filter
// Table-driven bench for rpsc_status_filter with DEB_CYCLES = 4. Each table
// row holds raw/ack for n cycles, and the expected outputs apply after every
// one of those cycles. Expected words go into exp_q when a cycle is driven.
// They are popped and compared 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_rpsc_status_filter;

  localparam int N_CH = 7;
  localparam int W    = 20;  // {filt, fault, first, trip, not_alarm, state}

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rpsc_status_filter_if #(.N_CH(N_CH)) bus ();

  rpsc_status_filter #(
    .N_CH      (N_CH),
    .DEB_WIDTH (14),
    .DEB_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [6:0] raw;
    logic       ack;
    int         n;
    logic [6:0] filt;
    logic [6:0] fault;
    logic [2:0] first;
    logic       trip;
    string      name;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  // Expected word. not_alarm is "no latch set", and the FSM is TRIPPED
  // exactly while a first-fault code is held.
  function automatic logic [W-1:0] pack_exp(input logic [6:0] filt,
                                            input logic [6:0] fault,
                                            input logic [2:0] first,
                                            input logic trip);
    return {filt, fault, first, trip, (fault == 7'd0), (first != 3'd0)};
  endfunction

  task automatic add(input logic [6:0] raw, input logic ack, input int n,
                     input logic [6:0] filt, input logic [6:0] fault,
                     input logic [2:0] first, input logic trip,
                     input string name);
    vec_t v;
    v.raw = raw; v.ack = ack; v.n = n; v.filt = filt; v.fault = fault;
    v.first = first; v.trip = trip; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name);
    logic [W-1:0] act;
    logic [W-1:0] expv;
    act = {bus.o_filt, bus.o_fault, bus.o_first, bus.o_trip,
           bus.o_not_alarm, bus.dbg_state};
    expv = exp_q.pop_front();
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%05h expected=%05h (filt,fault,first,trip,na,st)",
               name, act, expv);
    end
  endtask

  task automatic drive_cycle(input logic [6:0] raw, input logic ack,
                             input logic rst, input logic [W-1:0] expv,
                             input string name);
    @(negedge clk);
    bus.i_raw = raw;
    bus.i_ack = ack;
    reset     = rst;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    bus.i_raw = '0;
    bus.i_ack = 1'b0;
    reset     = 1'b1;

    // Clean trip on Water_Anode, then release and acknowledge.
    add(7'b0000100, 0, 5, 7'b0000000, 7'b0000000, 3'd0, 0, "clean_wait");
    add(7'b0000100, 0, 1, 7'b0000100, 7'b0000000, 3'd0, 0, "clean_filt");
    add(7'b0000100, 0, 1, 7'b0000100, 7'b0000100, 3'd3, 1, "clean_trip");
    add(7'b0000100, 0, 1, 7'b0000100, 7'b0000100, 3'd3, 0, "clean_trip_end");
    add(7'b0000000, 0, 5, 7'b0000100, 7'b0000100, 3'd3, 0, "clean_fall_wait");
    add(7'b0000000, 0, 1, 7'b0000000, 7'b0000100, 3'd3, 0, "clean_fall");
    add(7'b0000000, 1, 1, 7'b0000000, 7'b0000000, 3'd0, 0, "clean_ack");
    add(7'b0000000, 0, 2, 7'b0000000, 7'b0000000, 3'd0, 0, "idle1");
    // Bounce rejection on Card_POS.
    add(7'b0000001, 0, 3, 7'b0000000, 7'b0000000, 3'd0, 0, "bounce_hi1");
    add(7'b0000000, 0, 1, 7'b0000000, 7'b0000000, 3'd0, 0, "bounce_lo1");
    add(7'b0000001, 0, 3, 7'b0000000, 7'b0000000, 3'd0, 0, "bounce_hi2");
    add(7'b0000000, 0, 6, 7'b0000000, 7'b0000000, 3'd0, 0, "bounce_lo2");
    // Simultaneous rises resolve to the lowest index; later rise adds latch.
    add(7'b1000010, 0, 5, 7'b0000000, 7'b0000000, 3'd0, 0, "simul_wait");
    add(7'b1000010, 0, 1, 7'b1000010, 7'b0000000, 3'd0, 0, "simul_filt");
    add(7'b1000010, 0, 1, 7'b1000010, 7'b1000010, 3'd2, 1, "simul_trip");
    add(7'b1000010, 0, 1, 7'b1000010, 7'b1000010, 3'd2, 0, "simul_hold");
    add(7'b1010010, 0, 5, 7'b1000010, 7'b1000010, 3'd2, 0, "add4_wait");
    add(7'b1010010, 0, 1, 7'b1010010, 7'b1000010, 3'd2, 0, "add4_filt");
    add(7'b1010010, 0, 2, 7'b1010010, 7'b1010010, 3'd2, 0, "add4_latch");
    // Ack while contacts are active; then partial clear.
    add(7'b1010010, 1, 1, 7'b1010010, 7'b1010010, 3'd2, 0, "ack_active");
    add(7'b0000010, 0, 5, 7'b1010010, 7'b1010010, 3'd2, 0, "drop_wait");
    add(7'b0000010, 0, 1, 7'b0000010, 7'b1010010, 3'd2, 0, "drop_filt");
    add(7'b0000010, 1, 1, 7'b0000010, 7'b0000010, 3'd2, 0, "ack_partial");
    add(7'b0000010, 0, 1, 7'b0000010, 7'b0000010, 3'd2, 0, "tripped_hold");
    // Full clear.
    add(7'b0000000, 0, 5, 7'b0000010, 7'b0000010, 3'd2, 0, "clear_wait");
    add(7'b0000000, 0, 1, 7'b0000000, 7'b0000010, 3'd2, 0, "clear_filt");
    add(7'b0000000, 1, 1, 7'b0000000, 7'b0000000, 3'd0, 0, "full_clear");
    add(7'b0000000, 0, 2, 7'b0000000, 7'b0000000, 3'd0, 0, "idle2");
    // Rise coincident with ack: set wins; held ack acts every cycle.
    add(7'b0001000, 0, 5, 7'b0000000, 7'b0000000, 3'd0, 0, "sw_wait");
    add(7'b0001000, 0, 1, 7'b0001000, 7'b0000000, 3'd0, 0, "sw_filt");
    add(7'b0001000, 1, 1, 7'b0001000, 7'b0001000, 3'd4, 1, "set_wins");
    add(7'b0001000, 1, 2, 7'b0001000, 7'b0001000, 3'd4, 0, "ack_held_active");
    add(7'b0000000, 1, 5, 7'b0001000, 7'b0001000, 3'd4, 0, "ack_held_wait");
    add(7'b0000000, 1, 1, 7'b0000000, 7'b0001000, 3'd4, 0, "ack_held_fall");
    add(7'b0000000, 1, 1, 7'b0000000, 7'b0000000, 3'd0, 0, "ack_held_clear");
    add(7'b0000000, 0, 1, 7'b0000000, 7'b0000000, 3'd0, 0, "idle3");
    // Trip on U_CA_Low, to be wiped by reset below.
    add(7'b0100000, 0, 5, 7'b0000000, 7'b0000000, 3'd0, 0, "t6_wait");
    add(7'b0100000, 0, 1, 7'b0100000, 7'b0000000, 3'd0, 0, "t6_filt");
    add(7'b0100000, 0, 1, 7'b0100000, 7'b0100000, 3'd6, 1, "t6_trip");

    // Reset check.
    drive_cycle(7'b0, 0, 1, pack_exp(7'b0, 7'b0, 3'd0, 0), "reset_c1");
    drive_cycle(7'b0, 0, 1, pack_exp(7'b0, 7'b0, 3'd0, 0), "reset_c2");

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        drive_cycle(vecs[i].raw, vecs[i].ack, 1'b0,
                    pack_exp(vecs[i].filt, vecs[i].fault, vecs[i].first,
                             vecs[i].trip),
                    vecs[i].name);
      end
    end

    // Reset mid-trip discards latches, first code and state.
    drive_cycle(7'b0100000, 0, 1, pack_exp(7'b0, 7'b0, 3'd0, 0), "reset_mid_trip");

    // Reset mid-count: four edges of high input leave cnt at 2, then reset.
    for (int c = 0; c < 4; c++)
      drive_cycle(7'b0000001, 0, 0, pack_exp(7'b0, 7'b0, 3'd0, 0), "mc_pre");
    drive_cycle(7'b0000001, 0, 1, pack_exp(7'b0, 7'b0, 3'd0, 0), "mc_reset");
    for (int c = 0; c < 5; c++)
      drive_cycle(7'b0000001, 0, 0, pack_exp(7'b0, 7'b0, 3'd0, 0), "mc_restart_wait");
    drive_cycle(7'b0000001, 0, 0, pack_exp(7'b0000001, 7'b0, 3'd0, 0), "mc_filt");
    drive_cycle(7'b0000001, 0, 0, pack_exp(7'b0000001, 7'b0000001, 3'd1, 1), "mc_trip");
    drive_cycle(7'b0000001, 0, 0, pack_exp(7'b0000001, 7'b0000001, 3'd1, 0), "mc_trip_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
